// File: rtl/apu_result_rx.sv
// apu_result_rx: receive endpoint for the APU CNN result stream.
// Waits for a BCID header (nonzero TID_rd), takes the single TLAST result
// beat, reduces a full beat to an argmax over N_CLASSES signed int8 lanes,
// and queues one record per frame into a first-word fall-through FIFO.
// A watchdog produces a timeout record if no beat arrives.
//
// Optional build macro: APU_RESULT_RX_STATS_EN
//   adds saturating 16-bit counters cnt_ok/cnt_empty/cnt_timeout/cnt_err and
//   requires TSTRB_rd == TKEEP_rd on accepted beats.
//
// Handshakes: both streams use strict valid/ready. A transfer happens on a
// rising clk edge where valid and ready are both 1. Valid must not depend on
// ready. TREADY_rd depends only on registered state (FSM state, FIFO count).
// res_* outputs are registered FIFO contents and hold while res_valid=1 and
// res_ready=0.
//
// state_dbg encoding: 0=IDLE, 1=WAIT, 2=SCAN, 3=PUSH.
module apu_result_rx #(
   parameter int N_CLASSES  = 10,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic         clk,
   input  logic         ARESETn,
   input  logic         TVALID_rd,
   output logic         TREADY_rd,
   input  logic [127:0] TDATA_rd,
   input  logic [15:0]  TSTRB_rd,
   input  logic [15:0]  TKEEP_rd,
   input  logic         TLAST_rd,
   input  logic [10:0]  TID_rd,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [10:0]  res_bcid,
   output logic [3:0]   res_class,
   output logic [7:0]   res_score,
   output logic         res_empty,
   output logic         res_timeout,
   output logic         proto_err,
`ifdef APU_RESULT_RX_STATS_EN
   output logic [15:0]  cnt_ok,
   output logic [15:0]  cnt_empty,
   output logic [15:0]  cnt_timeout,
   output logic [15:0]  cnt_err,
`endif
   output logic [1:0]   state_dbg
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int WD_W  = $clog2(TIMEOUT) + 1;
   localparam logic [3:0]      LAST_K = 4'(N_CLASSES - 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_SCAN = 2'd2,
      S_PUSH = 2'd3
   } state_t;

   typedef struct packed {
      logic        timeout;
      logic        empty;
      logic [10:0] bcid;
      logic [3:0]  cls;
      logic [7:0]  score;
   } rec_t;

   state_t state_q, state_d;

   // frame datapath registers
   logic [10:0]     bcid_q;
   logic [127:0]    data_q;
   logic [3:0]      k_q;
   logic [7:0]      max_q;
   logic [3:0]      cls_q;
   logic            empty_q;
   logic            timeout_q;
   logic [WD_W-1:0] wd_q;
   logic            proto_err_q;

   // FSM control strobes
   logic start, accept, err_evt, push, pop;
   logic wd_clr, wd_inc;
   logic take_full, take_empty, take_timeout;
   logic strb_bad;
   logic [7:0] lane;

   // FIFO storage
   rec_t             mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             fifo_full;
   rec_t             rec_in, head;

`ifdef APU_RESULT_RX_STATS_EN
   assign strb_bad = (TSTRB_rd != TKEEP_rd);
`else
   logic unused_strb;
   assign unused_strb = ^TSTRB_rd;
   assign strb_bad    = 1'b0;
`endif

   assign fifo_full = (count_q == FULL_CNT);
   assign lane      = data_q[{k_q, 3'b000} +: 8];

   // FSM state register
   always_ff @(posedge clk or negedge ARESETn) begin
      if (!ARESETn) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // FSM next state, ready, and per-cycle control strobes
   always_comb begin
      state_d      = state_q;
      TREADY_rd    = 1'b0;
      start        = 1'b0;
      accept       = 1'b0;
      err_evt      = 1'b0;
      push         = 1'b0;
      wd_clr       = 1'b0;
      wd_inc       = 1'b0;
      take_full    = 1'b0;
      take_empty   = 1'b0;
      take_timeout = 1'b0;
      case (state_q)
         S_IDLE: begin
            // a beat offered before any header is a protocol violation
            if (TVALID_rd) err_evt = 1'b1;
            if (TID_rd != 11'd0) begin
               start   = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // only accept when a record slot is guaranteed for PUSH
            TREADY_rd = !fifo_full;
            accept    = TVALID_rd && !fifo_full;
            if (accept) begin
               wd_clr = 1'b1;
               if (strb_bad) err_evt = 1'b1;
               if (!TLAST_rd) begin
                  err_evt = 1'b1;
               end else if (TKEEP_rd == 16'hFFFF) begin
                  take_full = 1'b1;
                  state_d   = S_SCAN;
               end else begin
                  take_empty = 1'b1;
                  state_d    = S_PUSH;
                  if (TKEEP_rd != 16'h0000) err_evt = 1'b1;
               end
            end else if (wd_q == WD_MAX) begin
               // watchdog saturates here until the FIFO has room
               if (!fifo_full) begin
                  take_timeout = 1'b1;
                  state_d      = S_PUSH;
               end
            end else begin
               wd_inc = 1'b1;
            end
         end
         S_SCAN: begin
            if (k_q == LAST_K) state_d = S_PUSH;
         end
         S_PUSH: begin
            push    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // frame datapath: header latch, watchdog, beat capture and argmax scan
   always_ff @(posedge clk or negedge ARESETn) begin
      if (!ARESETn) begin
         bcid_q      <= '0;
         data_q      <= '0;
         k_q         <= '0;
         max_q       <= '0;
         cls_q       <= '0;
         empty_q     <= 1'b0;
         timeout_q   <= 1'b0;
         wd_q        <= '0;
         proto_err_q <= 1'b0;
      end else begin
         if (start) bcid_q <= TID_rd;
         if (start || wd_clr) wd_q <= '0;
         else if (wd_inc)     wd_q <= wd_q + 1'b1;
         if (take_full) begin
            data_q    <= TDATA_rd;
            k_q       <= '0;
            empty_q   <= 1'b0;
            timeout_q <= 1'b0;
         end
         if (take_empty) begin
            empty_q   <= 1'b1;
            timeout_q <= 1'b0;
            cls_q     <= 4'hF;
            max_q     <= 8'h00;
         end
         if (take_timeout) begin
            empty_q   <= 1'b0;
            timeout_q <= 1'b1;
            cls_q     <= 4'hF;
            max_q     <= 8'h00;
         end
         if (state_q == S_SCAN) begin
            k_q <= k_q + 1'b1;
            // strict compare keeps the lowest index on ties
            if ((k_q == 4'd0) || ($signed(lane) > $signed(max_q))) begin
               max_q <= lane;
               cls_q <= k_q;
            end
         end
         if (err_evt) proto_err_q <= 1'b1;
      end
   end

   assign rec_in = '{timeout: timeout_q, empty: empty_q, bcid: bcid_q,
                     cls: cls_q, score: max_q};
   assign pop    = res_valid && res_ready;

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage write
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= rec_in;
   end

   // outputs are zero whenever the FIFO is empty, including after reset
   assign res_valid   = (count_q != '0);
   assign head        = res_valid ? mem[rd_ptr_q] : '0;
   assign res_bcid    = head.bcid;
   assign res_class   = head.cls;
   assign res_score   = head.score;
   assign res_empty   = head.empty;
   assign res_timeout = head.timeout;
   assign proto_err   = proto_err_q;
   assign state_dbg   = state_q;

`ifdef APU_RESULT_RX_STATS_EN
   logic [15:0] cnt_ok_q, cnt_empty_q, cnt_timeout_q, cnt_err_q;

   // saturating statistics counters
   always_ff @(posedge clk or negedge ARESETn) begin
      if (!ARESETn) begin
         cnt_ok_q      <= '0;
         cnt_empty_q   <= '0;
         cnt_timeout_q <= '0;
         cnt_err_q     <= '0;
      end else begin
         if (push && !empty_q && !timeout_q && (cnt_ok_q != 16'hFFFF))
            cnt_ok_q <= cnt_ok_q + 1'b1;
         if (push && empty_q && (cnt_empty_q != 16'hFFFF))
            cnt_empty_q <= cnt_empty_q + 1'b1;
         if (push && timeout_q && (cnt_timeout_q != 16'hFFFF))
            cnt_timeout_q <= cnt_timeout_q + 1'b1;
         if (err_evt && (cnt_err_q != 16'hFFFF))
            cnt_err_q <= cnt_err_q + 1'b1;
      end
   end

   assign cnt_ok      = cnt_ok_q;
   assign cnt_empty   = cnt_empty_q;
   assign cnt_timeout = cnt_timeout_q;
   assign cnt_err     = cnt_err_q;
`endif

endmodule

// File: tb/tb_apu_result_rx.sv
// tb_apu_result_rx: directed bench for apu_result_rx (default parameters).
module tb_apu_result_rx;

   logic         clk;
   logic         ARESETn;
   logic         TVALID_rd;
   logic         TREADY_rd;
   logic [127:0] TDATA_rd;
   logic [15:0]  TSTRB_rd;
   logic [15:0]  TKEEP_rd;
   logic         TLAST_rd;
   logic [10:0]  TID_rd;
   logic         res_valid;
   logic         res_ready;
   logic [10:0]  res_bcid;
   logic [3:0]   res_class;
   logic [7:0]   res_score;
   logic         res_empty;
   logic         res_timeout;
   logic         proto_err;
   logic [1:0]   state_dbg;
`ifdef APU_RESULT_RX_STATS_EN
   logic [15:0]  cnt_ok, cnt_empty, cnt_timeout, cnt_err;
`endif

   int errors;
   int checks;
   logic [10:0] exp_q[$];

   apu_result_rx dut (
      .clk         (clk),
      .ARESETn     (ARESETn),
      .TVALID_rd   (TVALID_rd),
      .TREADY_rd   (TREADY_rd),
      .TDATA_rd    (TDATA_rd),
      .TSTRB_rd    (TSTRB_rd),
      .TKEEP_rd    (TKEEP_rd),
      .TLAST_rd    (TLAST_rd),
      .TID_rd      (TID_rd),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_bcid    (res_bcid),
      .res_class   (res_class),
      .res_score   (res_score),
      .res_empty   (res_empty),
      .res_timeout (res_timeout),
      .proto_err   (proto_err),
`ifdef APU_RESULT_RX_STATS_EN
      .cnt_ok      (cnt_ok),
      .cnt_empty   (cnt_empty),
      .cnt_timeout (cnt_timeout),
      .cnt_err     (cnt_err),
`endif
      .state_dbg   (state_dbg)
   );

   // clock and global time limit
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
      $fatal(1, "bench time limit");
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_header(input logic [10:0] id);
      TID_rd = id;
      step();
      TID_rd = '0;
   endtask

   task automatic send_beat(input logic [15:0] keep, input logic last, input logic [127:0] data);
      int w;
      w = 0;
      TVALID_rd = 1'b1;
      TKEEP_rd  = keep;
      TSTRB_rd  = keep;
      TLAST_rd  = last;
      TDATA_rd  = data;
      while (!TREADY_rd && w < 50) begin
         step();
         w++;
      end
      if (!TREADY_rd) begin
         checks++;
         errors++;
         $display("FAIL beat_accept: TREADY_rd=%0b after %0d cycles, required 1", TREADY_rd, w);
      end else begin
         step();
      end
      TVALID_rd = 1'b0;
      TLAST_rd  = 1'b0;
   endtask

   task automatic wait_record(input int budget, output int n);
      n = 0;
      while (!res_valid && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (res_valid !== 1'b1) begin
         errors++;
         $display("FAIL record_wait: res_valid=%0b after %0d cycles, required 1", res_valid, n);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      ARESETn   = 1'b0;
      TVALID_rd = 1'b0;
      TDATA_rd  = '0;
      TSTRB_rd  = '0;
      TKEEP_rd  = '0;
      TLAST_rd  = 1'b0;
      TID_rd    = '0;
      res_ready = 1'b1;
      #2;
      checks++;
      if ({TREADY_rd, res_valid, proto_err} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl: tready/valid/err=%b, required 000", {TREADY_rd, res_valid, proto_err});
      end
      checks++;
      if ({res_bcid, res_class, res_score, res_empty, res_timeout} !== 25'd0) begin
         errors++;
         $display("FAIL reset_res: res fields=%h, required 0", {res_bcid, res_class, res_score, res_empty, res_timeout});
      end
      checks++;
      if (state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: state=%0d, required 0", state_dbg);
      end
      repeat (2) @(posedge clk);
      #1 ARESETn = 1'b1;
      step();
      checks++;
      if ({TREADY_rd, res_valid} !== 2'b00) begin
         errors++;
         $display("FAIL idle_after_reset: tready/valid=%b, required 00", {TREADY_rd, res_valid});
      end
   endtask

   task automatic test_full();
      int n;
      int bad;
      bad = 0;
      send_header(11'd7);
      repeat (3) begin
         if (TREADY_rd !== 1'b1) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL full_wait_ready: %0d WAIT cycles with TREADY_rd=0, required 0", bad);
      end
      send_beat(16'hFFFF, 1'b1,
                {48'h0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h80, 8'h7F, 8'h05});
      wait_record(40, n);
      checks++;
      if (n + 1 != 12) begin
         errors++;
         $display("FAIL full_latency: res_valid at cycle %0d, required 12", n + 1);
      end
      checks++;
      if ({res_bcid, res_class, res_score, res_empty, res_timeout} !== {11'd7, 4'd1, 8'h7F, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL full_record: bcid=%h class=%h score=%h empty=%b timeout=%b, required 007 1 7f 0 0",
                  res_bcid, res_class, res_score, res_empty, res_timeout);
      end
      step();
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_pop: res_valid=%b, required 0", res_valid);
      end
   endtask

   task automatic test_empty();
      int n;
      send_header(11'h3FF);
      send_beat(16'h0000, 1'b1, 128'h0);
      wait_record(10, n);
      checks++;
      if (n + 1 != 2) begin
         errors++;
         $display("FAIL empty_latency: res_valid at cycle %0d, required 2", n + 1);
      end
      checks++;
      if ({res_bcid, res_class, res_score, res_empty, res_timeout} !== {11'h3FF, 4'hF, 8'h00, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL empty_record: bcid=%h class=%h score=%h empty=%b timeout=%b, required 3ff f 00 1 0",
                  res_bcid, res_class, res_score, res_empty, res_timeout);
      end
      step();
   endtask

   task automatic test_timeout();
      int n;
      send_header(11'd5);
      wait_record(1100, n);
      checks++;
      if (n != 1025) begin
         errors++;
         $display("FAIL timeout_latency: record %0d cycles after WAIT entry, required 1025", n);
      end
      checks++;
      if ({res_bcid, res_class, res_score, res_empty, res_timeout} !== {11'd5, 4'hF, 8'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL timeout_record: bcid=%h class=%h score=%h empty=%b timeout=%b, required 005 f 00 0 1",
                  res_bcid, res_class, res_score, res_empty, res_timeout);
      end
      checks++;
      if (proto_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_no_err: proto_err=%b, required 0", proto_err);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [127:0] d;
      logic [10:0]  e;
      int bad, got, guard;
      logic acc;
      res_ready = 1'b0;
      exp_q.delete();
      for (int b = 1; b <= 4; b++) begin
         d = '0;
         d[8*b +: 8] = 8'h40;
         send_header(11'(b));
         send_beat(16'hFFFF, 1'b1, d);
         exp_q.push_back(11'(b));
         repeat (12) step();
      end
      checks++;
      if ({res_valid, res_bcid} !== {1'b1, 11'd1}) begin
         errors++;
         $display("FAIL bp_head: valid=%b bcid=%h, required 1 001", res_valid, res_bcid);
      end
      send_header(11'd5);
      exp_q.push_back(11'd5);
      d = '0;
      d[47:40] = 8'h40;
      TVALID_rd = 1'b1;
      TKEEP_rd  = 16'hFFFF;
      TSTRB_rd  = 16'hFFFF;
      TLAST_rd  = 1'b1;
      TDATA_rd  = d;
      bad = 0;
      repeat (5) begin
         if (TREADY_rd !== 1'b0) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_tready: TREADY_rd high %0d cycles with FIFO full, required 0", bad);
      end
      res_ready = 1'b1;
      got = 0;
      guard = 0;
      while (got < 5 && guard < 60) begin
         acc = TVALID_rd && TREADY_rd;
         if (res_valid) begin
            e = exp_q.pop_front();
            checks++;
            if ({res_bcid, res_class, res_score} !== {e, e[3:0], 8'h40}) begin
               errors++;
               $display("FAIL bp_order: bcid=%h class=%h score=%h, required %h %h 40",
                        res_bcid, res_class, res_score, e, e[3:0]);
            end
            got++;
         end
         step();
         guard++;
         if (acc) begin
            TVALID_rd = 1'b0;
            TLAST_rd  = 1'b0;
         end
      end
      checks++;
      if (got != 5) begin
         errors++;
         $display("FAIL bp_count: popped %0d records, required 5", got);
      end
      TVALID_rd = 1'b0;
   endtask

   task automatic test_proto();
      logic [127:0] d;
      int n;
      TVALID_rd = 1'b1;
      step();
      TVALID_rd = 1'b0;
      checks++;
      if ({proto_err, TREADY_rd, res_valid} !== 3'b100) begin
         errors++;
         $display("FAIL proto_idle: err/tready/valid=%b, required 100", {proto_err, TREADY_rd, res_valid});
      end
      send_header(11'd9);
      d = '0;
      d[47:40] = 8'h7F;
      send_beat(16'hFFFF, 1'b0, d);
      d = {16{8'h80}};
      d[23:16] = 8'hFF;
      send_beat(16'hFFFF, 1'b1, d);
      wait_record(40, n);
      checks++;
      if (n + 1 != 12) begin
         errors++;
         $display("FAIL proto_drop_latency: res_valid at cycle %0d, required 12", n + 1);
      end
      checks++;
      if ({res_bcid, res_class, res_score, res_empty, res_timeout} !== {11'd9, 4'd2, 8'hFF, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL proto_record: bcid=%h class=%h score=%h empty=%b timeout=%b, required 009 2 ff 0 0",
                  res_bcid, res_class, res_score, res_empty, res_timeout);
      end
      step();
      checks++;
      if ({proto_err, res_valid} !== 2'b10) begin
         errors++;
         $display("FAIL proto_sticky: err/valid=%b, required 10", {proto_err, res_valid});
      end
   endtask

   task automatic test_reset_mid_scan();
      int n;
      res_ready = 1'b0;
      send_header(11'h011);
      send_beat(16'h0000, 1'b1, 128'h0);
      wait_record(10, n);
      send_header(11'h022);
      send_beat(16'hFFFF, 1'b1, {16{8'h11}});
      repeat (3) step();
      checks++;
      if (state_dbg !== 2'd2) begin
         errors++;
         $display("FAIL mid_scan_state: state=%0d, required 2", state_dbg);
      end
      ARESETn = 1'b0;
      #1;
      checks++;
      if ({res_valid, TREADY_rd, proto_err} !== 3'b000) begin
         errors++;
         $display("FAIL mid_scan_reset: valid/tready/err=%b, required 000", {res_valid, TREADY_rd, proto_err});
      end
      @(posedge clk);
      #1 ARESETn = 1'b1;
      repeat (3) step();
      checks++;
      if ({res_valid, TREADY_rd} !== 2'b00) begin
         errors++;
         $display("FAIL post_reset_empty: valid/tready=%b, required 00", {res_valid, TREADY_rd});
      end
      res_ready = 1'b1;
      send_header(11'h033);
      send_beat(16'h0000, 1'b1, 128'h0);
      wait_record(10, n);
      checks++;
      if ({res_bcid, res_empty} !== {11'h033, 1'b1}) begin
         errors++;
         $display("FAIL post_reset_record: bcid=%h empty=%b, required 033 1", res_bcid, res_empty);
      end
      step();
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_drain: res_valid=%b, required 0", res_valid);
      end
   endtask

   task automatic test_bad_keep();
      int n;
      send_header(11'h044);
      send_beat(16'h00FF, 1'b1, {16{8'h22}});
      wait_record(10, n);
      checks++;
      if ({res_bcid, res_class, res_score, res_empty, res_timeout, proto_err} !==
          {11'h044, 4'hF, 8'h00, 1'b1, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL bad_keep: bcid=%h class=%h score=%h empty=%b timeout=%b err=%b, required 044 f 00 1 0 1",
                  res_bcid, res_class, res_score, res_empty, res_timeout, proto_err);
      end
      checks++;
      if (n + 1 != 2) begin
         errors++;
         $display("FAIL bad_keep_latency: res_valid at cycle %0d, required 2", n + 1);
      end
      step();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_full();
      test_empty();
      test_timeout();
      test_back_to_back();
      test_proto();
      test_reset_mid_scan();
      test_bad_keep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/apu_result_rx.md
Name: apu_result_rx

Overview:
- Receive-side endpoint for the APU CNN result stream; sits downstream of the conv2d APU wrapper's write-side AXI-Stream port.
- Captures the BCID header (nonzero TID with no data), then takes the single TLAST result beat.
- Classifies the beat as full (10 signed int8 scores) or empty (TKEEP=0 marker); a full beat is reduced to an argmax.
- Queues one result record per frame to host logic through a valid/ready FIFO; a watchdog emits a timeout record if the APU never answers.

Parameters:
- N_CLASSES, 10, number of signed 8-bit score lanes in TDATA[8*N_CLASSES-1:0]; legal range 1..16.
- FIFO_DEPTH, 4, result record FIFO entries; must be a power of 2, at least 2.
- TIMEOUT, 1024, cycles spent in WAIT without an accepted beat before a timeout record is produced.

Ports:
- clk  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- TVALID_rd  in  1  result beat valid.
- TREADY_rd  out  1  result beat ready.
- TDATA_rd  in  128  lane i = TDATA_rd[8i+7:8i], signed.
- TSTRB_rd  in  16  ignored, except in the optional feature.
- TKEEP_rd  in  16  16'hFFFF = full result; 16'h0000 = empty result.
- TLAST_rd  in  1  final beat of frame.
- TID_rd  in  11  BCID header, sampled in IDLE.
- res_valid  out  1  record available at FIFO head.
- res_ready  in  1  host pops the record.
- res_bcid  out  11  BCID of the record.
- res_class  out  4  argmax index; 4'hF for empty or timeout records.
- res_score  out  8  signed max score; 0 for empty or timeout records.
- res_empty  out  1  record came from an empty (TKEEP=0) beat.
- res_timeout  out  1  record came from the watchdog.
- proto_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (asynchronous, ARESETn=0): state=IDLE; FIFO flushed; TREADY_rd=0; res_valid=0; all res_* outputs=0; proto_err=0; watchdog=0.
- A reset mid-frame discards the frame silently.
- IDLE:
  - TREADY_rd=0.
  - If TID_rd!=0, latch bcid=TID_rd and go to WAIT; the watchdog is cleared on entry.
  - TID_rd==0 keeps the block in IDLE.
  - TVALID_rd=1 while in IDLE sets proto_err; the beat is not accepted.
- WAIT:
  - TREADY_rd = !fifo_full.
  - A beat is accepted when TVALID_rd & TREADY_rd.
  - Accepted with TLAST_rd=0: dropped, proto_err set, stay in WAIT, watchdog cleared.
  - Accepted with TLAST_rd=1 and TKEEP_rd==16'hFFFF: latch TDATA_rd, go to SCAN.
  - Accepted with TLAST_rd=1 and TKEEP_rd==0: go to PUSH with empty=1.
  - Accepted with TLAST_rd=1 and any other TKEEP_rd: go to PUSH with empty=1 and set proto_err.
  - A cycle with no accepted beat increments the watchdog.
  - Watchdog reaching TIMEOUT-1 with fifo not full: go to PUSH with timeout=1.
  - Watchdog reaching TIMEOUT-1 with fifo full: the watchdog saturates and the block waits.
- SCAN (TREADY_rd=0):
  - Lane counter k runs 0..N_CLASSES-1, one lane per cycle.
  - max initialises to lane 0.
  - Lane k replaces the current max only if signed lane k > max (strict), so ties keep the lowest index.
  - After lane N_CLASSES-1, go to PUSH.
- PUSH:
  - Write one record {timeout, empty, bcid, class, score} into the FIFO, then go to IDLE.
  - Space is guaranteed because fifo_full was checked at acceptance or timeout and pops only free space.
- Latency from the accept edge (cycle 0) to res_valid, with the FIFO initially empty:
  - Full result: cycle N_CLASSES+2.
  - Empty result: cycle 2.
  - Timeout: cycle 2 after the watchdog fires.
- FIFO:
  - First-word fall-through: the res_* outputs show the head entry whenever res_valid=1.
  - A pop occurs on res_valid & res_ready.
  - Push and pop in the same cycle are both honoured and occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - res_* outputs hold stable while res_valid=1 and res_ready=0.

Optional Feature:
- Macro APU_RESULT_RX_STATS_EN.
- Defined:
  - Adds 16-bit output counters cnt_ok, cnt_empty, cnt_timeout and cnt_err, incremented on the PUSH of the matching record type or on each proto_err event.
  - Counters saturate at 16'hFFFF and reset to 0.
  - Also requires TSTRB_rd==TKEEP_rd on accepted beats; a mismatch sets proto_err.
- Undefined: no counters, no ports for them, and TSTRB_rd is fully ignored.

Test Plan:
- Full result:
  - Stimulus: reset; TID_rd=7 for one cycle; 3 idle cycles; beat TKEEP=FFFF, TLAST=1, lanes = {0x05,0x7F,0x80,0x7F,0,0,0,0,0,0x10} (lanes 0..9); res_ready=1.
  - Required: res_valid at cycle 12 after accept with bcid=7, class=1, score=0x7F, empty=0, timeout=0.
- Empty result:
  - Stimulus: TID_rd=0x3FF header; beat TKEEP=0000, TLAST=1.
  - Required: record bcid=0x3FF, class=4'hF, score=0, empty=1, 2 cycles after accept.
- Timeout:
  - Stimulus: TID_rd=5 header, then no beat for 1024 cycles.
  - Required: record bcid=5, timeout=1, class=4'hF.
- FIFO backpressure:
  - Stimulus: res_ready=0; 5 full frames with BCIDs 1..5.
  - Required: 4 records queue; TREADY_rd stays 0 during frame 5's WAIT.
  - Then: raise res_ready; BCIDs 1..5 are popped in order.
- Protocol errors:
  - Stimulus (a): TVALID_rd=1 while in IDLE.
  - Stimulus (b): a non-TLAST beat in WAIT.
  - Required: proto_err=1 after (a) and stays 1; in (b) the beat is dropped and the later TLAST beat still produces the correct record.
- Reset mid-SCAN:
  - Stimulus: assert ARESETn=0 in SCAN cycle 4.
  - Required: res_valid=0 and TREADY_rd=0 immediately; FIFO empty after release.
